// File: rtl/shy_input_pkg.sv
// Shared event kinds, key codes and command strobe indices for the input dispatcher.
package shy_input_pkg;

    typedef enum logic [1:0] {
        EV_KEY   = 2'd0,
        EV_MOUSE = 2'd1,
        EV_QUIT  = 2'd2,
        EV_OTHER = 2'd3
    } ev_kind_e;

    localparam logic [7:0] KEY_ESCAPE = 8'h1B;
    localparam logic [7:0] KEY_RETURN = 8'h0D;
    localparam logic [7:0] KEY_COMMA  = 8'h2C;
    localparam logic [7:0] KEY_MINUS  = 8'h2D;
    localparam logic [7:0] KEY_K0     = 8'h30;
    localparam logic [7:0] KEY_K1     = 8'h31;
    localparam logic [7:0] KEY_K2     = 8'h32;
    localparam logic [7:0] KEY_K3     = 8'h33;
    localparam logic [7:0] KEY_K4     = 8'h34;
    localparam logic [7:0] KEY_F      = 8'h66;
    localparam logic [7:0] KEY_L      = 8'h6C;
    localparam logic [7:0] KEY_S      = 8'h73;
    localparam logic [7:0] KEY_F1     = 8'h81;
    localparam logic [7:0] KEY_F2     = 8'h82;
    localparam logic [7:0] KEY_F3     = 8'h83;
    localparam logic [7:0] KEY_F11    = 8'h8B;
    localparam logic [7:0] KEY_LALT   = 8'hE2;
    localparam logic [7:0] KEY_RALT   = 8'hE6;

    localparam int CMD_W         = 16;
    localparam int CMD_SHUTDOWN  = 0;
    localparam int CMD_TOGGLE_FS = 1;
    localparam int CMD_STATUS    = 2;
    localparam int CMD_FPS       = 3;
    localparam int CMD_PERF_CNT  = 4;
    localparam int CMD_PERF_FREQ = 5;
    localparam int CMD_LOG_ON    = 6;
    localparam int CMD_TOG_FLOOD = 7;
    localparam int CMD_LOG_OFF   = 8;
    localparam int CMD_TOG_DEBUG = 9;
    localparam int CMD_TOG_INFO  = 10;
    localparam int CMD_TOG_WARN  = 11;
    localparam int CMD_TOG_ERROR = 12;
    localparam int CMD_TOG_CRIT  = 13;
    localparam int CMD_RESERVED  = 14;

endpackage

// File: rtl/shy_rr_arbiter.sv
// N-way round-robin arbiter; the search starts at the pointer, which moves past each winner.
module shy_rr_arbiter #(
    parameter int N = 3,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    input  logic         en_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o,
    output logic         any_o
);
    logic [W-1:0] ptr_q, ptr_d;
    int           c;
    int           win;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        ptr_d = ptr_q;
        c     = 0;
        win   = 0;
        if (en_i) begin
            for (int i = 0; i < N; i++) begin
                c = int'(ptr_q) + i;
                if (c >= N) c = c - N;
                if (!any_o && req_i[c]) begin
                    any_o    = 1'b1;
                    win      = c;
                    gnt_o[c] = 1'b1;
                end
            end
        end
        if (any_o) begin
            idx_o = W'(win);
            ptr_d = W'((win + 1) % N);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/shy_event_dispatcher.sv
// Arbitrates input event sources into one registered stream and decodes key chords
// against the held-key bitmap into single-cycle command strobes.
module shy_event_dispatcher
    import shy_input_pkg::*;
#(
    parameter int N_SRC    = 3,
    parameter int DEV_MODE = 1,
    parameter int KEY_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_SRC-1:0]         src_valid,
    output logic [N_SRC-1:0]         src_ready,
    input  logic [2*N_SRC-1:0]       src_kind,
    input  logic [N_SRC-1:0]         src_state,
    input  logic [KEY_W*N_SRC-1:0]   src_key,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(N_SRC)-1:0] out_src,
    output logic [1:0]               out_kind,
    output logic                     out_state,
    output logic [KEY_W-1:0]         out_key,
    output logic [CMD_W-1:0]         cmd_pulse,
    output logic                     alt_held
);
    localparam int SW = $clog2(N_SRC);
    localparam int NK = 2 ** KEY_W;

    function automatic logic [KEY_W-1:0] kc(input logic [7:0] code);
        return KEY_W'(code);
    endfunction

    logic [N_SRC-1:0] gnt;
    logic [SW-1:0]    gnt_idx;
    logic             gnt_any;
    logic             can_accept;

    logic             out_valid_q;
    logic [SW-1:0]    out_src_q;
    logic [1:0]       out_kind_q;
    logic             out_state_q;
    logic [KEY_W-1:0] out_key_q;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic [NK-1:0]    bm_q, bm_d;

    int               gi;
    ev_kind_e         ev_kind;
    logic             ev_state;
    logic [KEY_W-1:0] ev_key;
    logic             ev_down;
    logic             alt_now;

    assign can_accept = !out_valid_q || out_ready;

    shy_rr_arbiter #(.N(N_SRC), .W(SW)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (src_valid),
        .en_i  (can_accept && !rst),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    assign src_ready = gnt;

    always_comb begin
        gi       = int'(gnt_idx);
        ev_kind  = ev_kind_e'(src_kind[gi*2 +: 2]);
        ev_state = src_state[gi];
        ev_key   = src_key[gi*KEY_W +: KEY_W];
        bm_d     = bm_q;
        cmd_d    = '0;
        if (gnt_any && ev_kind == EV_KEY) bm_d[ev_key] = ev_state;
        ev_down  = gnt_any && ev_kind == EV_KEY && ev_state;
        // Chord checks see the post-event bitmap so the chord's own key counts as held.
        alt_now  = bm_d[kc(KEY_LALT)] || bm_d[kc(KEY_RALT)];

        if (gnt_any && ev_kind == EV_QUIT) cmd_d[CMD_SHUTDOWN] = 1'b1;
        if (ev_down) begin
            if (ev_key == kc(KEY_ESCAPE))
                cmd_d[CMD_SHUTDOWN] = 1'b1;
            else if (ev_key == kc(KEY_F) || ev_key == kc(KEY_F11) ||
                     (ev_key == kc(KEY_RETURN) && alt_now))
                cmd_d[CMD_TOGGLE_FS] = 1'b1;

            if (DEV_MODE != 0 && bm_d[kc(KEY_COMMA)]) begin
                if      (ev_key == kc(KEY_S))  cmd_d[CMD_STATUS]    = 1'b1;
                else if (ev_key == kc(KEY_F1)) cmd_d[CMD_FPS]       = 1'b1;
                else if (ev_key == kc(KEY_F2)) cmd_d[CMD_PERF_CNT]  = 1'b1;
                else if (ev_key == kc(KEY_F3)) cmd_d[CMD_PERF_FREQ] = 1'b1;
                else if (bm_d[kc(KEY_L)]) begin
                    cmd_d[CMD_LOG_ON] = 1'b1;
                    if (ev_key == kc(KEY_F))
                        cmd_d[CMD_TOG_FLOOD] = 1'b1;
                    else if (ev_key == kc(KEY_MINUS) || bm_d[kc(KEY_MINUS)])
                        cmd_d[CMD_LOG_OFF] = 1'b1;
                    else if (ev_key == kc(KEY_K0)) cmd_d[CMD_TOG_DEBUG] = 1'b1;
                    else if (ev_key == kc(KEY_K1)) cmd_d[CMD_TOG_INFO]  = 1'b1;
                    else if (ev_key == kc(KEY_K2)) cmd_d[CMD_TOG_WARN]  = 1'b1;
                    else if (ev_key == kc(KEY_K3)) cmd_d[CMD_TOG_ERROR] = 1'b1;
                    else if (ev_key == kc(KEY_K4)) cmd_d[CMD_TOG_CRIT]  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
            out_kind_q  <= '0;
            out_state_q <= 1'b0;
            out_key_q   <= '0;
            cmd_q       <= '0;
            bm_q        <= '0;
        end else begin
            bm_q  <= bm_d;
            cmd_q <= cmd_d;
            if (gnt_any) begin
                out_valid_q <= 1'b1;
                out_src_q   <= gnt_idx;
                out_kind_q  <= ev_kind;
                out_state_q <= ev_state;
                out_key_q   <= ev_key;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;
    assign out_kind  = out_kind_q;
    assign out_state = out_state_q;
    assign out_key   = out_key_q;
    assign cmd_pulse = cmd_q;
    assign alt_held  = bm_q[kc(KEY_LALT)] || bm_q[kc(KEY_RALT)];

endmodule
